// File: rtl/timer.sv
// ---------------------------------------------------------------------------
// timer
//
// Programmable terminal-count timer. A WIDTH-bit down-counter decrements by
// one on every clock where count_en is high. When an enabled clock finds the
// counter at zero, the counter reloads from load_value and a single-cycle
// pulse is registered on out. The output period is therefore load_value+1
// enabled cycles. out is a plain pulse; any blink or duty-cycle shaping is
// done downstream.
//
// Ports
//   clk         in   1      single clock, all state changes on rising edge
//   reset       in   1      synchronous, active-low; reloads the counter from
//                           load_value and clears out, regardless of count_en
//   load_value  in   WIDTH  reload value, sampled only at reset and at reload
//   count_en    in   1      level-sensitive count enable, one step per clock
//   out         out  1      registered terminal-count pulse, one cycle wide
//
// Handshake
//   There is no valid/ready pair. count_en is a plain level qualifier: every
//   rising clk with count_en=1 is one count step, with no edge detection.
//   out is valid on every cycle after the first reset edge and is high for
//   exactly the cycle following the enabled edge that found cnt==0.
//
// Timing
//   out is driven straight from a flop; there is no combinational path from
//   any input to out.
//
// State
//   cnt and out are the only state. Neither has a power-on value; both are
//   undefined until the first rising clk with reset=0.
// ---------------------------------------------------------------------------
module timer #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_value,
    input  logic             count_en,
    output logic             out
);

    // Down-counter holding the number of enabled cycles still to go before
    // the next terminal count.
    logic [WIDTH-1:0] cnt;

    // Terminal count: the counter has run down and the next enabled edge
    // reloads instead of decrementing, so the counter never wraps below 0.
    logic cnt_zero;
    assign cnt_zero = (cnt == '0);

    // Next-state decode kept separate from the flops so the step/reload
    // decision is visible as named signals.
    logic             do_step;
    logic             do_reload;
    logic [WIDTH-1:0] cnt_next;
    logic             out_next;

    always_comb begin
        do_step   = count_en;
        do_reload = count_en && cnt_zero;
        cnt_next  = cnt;
        out_next  = 1'b0;
        if (do_reload) begin
            // load_value is only sampled here (and at reset), so a change
            // mid-count takes effect at the start of the next period.
            cnt_next = load_value;
            out_next = 1'b1;
        end else if (do_step) begin
            cnt_next = cnt - 1'b1;
        end
    end

    // Reset has priority over counting: a period in progress is abandoned
    // without a pulse and counting restarts from a fresh load_value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= load_value;
            out <= 1'b0;
        end else begin
            cnt <= cnt_next;
            out <= out_next;
        end
    end

endmodule

// File: tb/tb_timer.sv
// ---------------------------------------------------------------------------
// tb_timer
//
// Directed bench for timer (WIDTH=9). The driver applies one input vector per
// clock and pushes the expected value of out for the following cycle onto
// exp_q, using a reference model that counts enabled cycles remaining in the
// current period. An independent monitor pops one entry per clock and
// compares it with out. Each scenario also checks the number of pulses seen
// against a hand-computed total.
// ---------------------------------------------------------------------------
module tb_timer;

  localparam int WIDTH = 9;

  // -------------------------------------------------------------------------
  // Clock / reset block
  // -------------------------------------------------------------------------
  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] load_value;
  logic             count_en;
  logic             out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  timer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_value (load_value),
    .count_en   (count_en),
    .out        (out)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  logic [0:0] exp_q[$];
  int         total;
  int         bad;
  int         obs_pulses;

  // Reference model: enabled cycles still needed before the next pulse.
  int         m_left;

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  // Apply one vector, predict out for the next cycle, then advance one clock.
  // Returns 3 time units after the edge, after the monitor has sampled.
  task automatic cycle(input logic rst_n, input logic en, input int lv);
    logic [0:0] e;
    reset      = rst_n;
    count_en   = en;
    load_value = lv[WIDTH-1:0];
    e = 1'b0;
    if (!rst_n) begin
      m_left = lv + 1;
    end else if (en) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        e = 1'b1;
        m_left = lv + 1;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #3;
  endtask

  task automatic run(input int n, input logic en, input int lv);
    for (int i = 0; i < n; i++) cycle(1'b1, en, lv);
  endtask

  // One enable every `spacing` clocks, `n` enables in total.
  task automatic run_sparse(input int n, input int spacing, input int lv);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b1, lv);
      for (int j = 1; j < spacing; j++) cycle(1'b1, 1'b0, lv);
    end
  endtask

  task automatic check_pulses(input string name, input int expected);
    total++;
    if (obs_pulses != expected) begin
      bad++;
      $display("FAIL %s: pulses=%0d expected=%0d", name, obs_pulses, expected);
    end
    obs_pulses = 0;
  endtask

  // -------------------------------------------------------------------------
  // Monitor: one comparison per clock once expectations exist
  // -------------------------------------------------------------------------
  initial begin
    logic [0:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (out === 1'b1) obs_pulses++;
        if (out !== e) begin
          bad++;
          $display("FAIL out @%0t: got=%b expected=%b", $time, out, e);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    total      = 0;
    bad        = 0;
    obs_pulses = 0;
    m_left     = 0;
    reset      = 1'b1;
    count_en   = 1'b0;
    load_value = '0;
    @(negedge clk);

    // Reset with count_en high: out must still be 0, counting starts fresh.
    cycle(1'b0, 1'b1, 8);
    check_pulses("reset_state", 0);

    // Continuous enable, load 8: pulses on cycles 9, 18, 27.
    run(27, 1'b1, 8);
    check_pulses("cont_load8", 3);

    // One enable in every 6 clocks: 18 enables -> 2 pulses, 54 clk apart.
    cycle(1'b0, 1'b0, 8);
    run_sparse(18, 6, 8);
    check_pulses("sparse_en6", 2);

    // Reset mid-period aborts without a pulse; next pulse after 9 enables.
    cycle(1'b0, 1'b0, 8);
    run(4, 1'b1, 8);
    cycle(1'b0, 1'b0, 8);
    check_pulses("abort_no_pulse", 0);
    run(8, 1'b1, 8);
    check_pulses("after_abort_8", 0);
    run(1, 1'b1, 8);
    check_pulses("after_abort_9", 1);

    // load_value 8->3 after 2 enables: period ends after 9, then 4-enable periods.
    cycle(1'b0, 1'b0, 8);
    run(2, 1'b1, 8);
    run(7, 1'b1, 3);
    check_pulses("lv_change_first", 1);
    run(8, 1'b1, 3);
    check_pulses("lv_change_next", 2);

    // 100 idle cycles mid-period: counter holds, pulse after remaining enables.
    cycle(1'b0, 1'b0, 8);
    run(5, 1'b1, 8);
    run(100, 1'b0, 8);
    run(3, 1'b1, 8);
    check_pulses("hold_idle", 0);
    run(1, 1'b1, 8);
    check_pulses("hold_done", 1);

    // load_value 0: pulse every enabled cycle; toggling -> every other cycle.
    cycle(1'b0, 1'b0, 0);
    run(10, 1'b1, 0);
    check_pulses("lv0_cont", 10);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 0);
      cycle(1'b1, 1'b0, 0);
    end
    check_pulses("lv0_toggle", 5);

    // Maximum load: period is 512 enables, no wrap below zero.
    cycle(1'b0, 1'b0, 511);
    run(511, 1'b1, 511);
    check_pulses("lvmax_early", 0);
    run(1, 1'b1, 511);
    check_pulses("lvmax_pulse", 1);
    run(512, 1'b1, 511);
    check_pulses("lvmax_second", 1);

    // Every pushed expectation must have been consumed.
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: left=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 Parameter: WIDTH, default 9, bit width of load_value and of the internal down-counter.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  reset, synchronous and active-low; sampled only on rising clk.
REQ-004 Port: load_value  input  WIDTH  reload value; output period = load_value+1 enabled cycles.
REQ-005 Port: count_en  input  1  count-enable strobe; counter advances only on cycles where it is 1.
REQ-006 Port: out  output  1  registered terminal-count pulse, one clk cycle wide.

Function
REQ-007 Internal state SHALL be the WIDTH-bit down-counter cnt and the out register; there is no other state.
REQ-008 On a rising clk with count_en=1 and cnt!=0, cnt SHALL decrement by 1 and out SHALL be 0 in the next cycle.
REQ-009 On a rising clk with count_en=1 and cnt==0, cnt SHALL reload with load_value and out SHALL be 1 for exactly the next cycle.
REQ-010 On a rising clk with count_en=0, cnt SHALL hold and out SHALL be 0 in the next cycle.
REQ-011 Latency: out SHALL rise on the clk edge that samples count_en=1 with cnt==0; no combinational path from any input to out.
REQ-012 The first pulse after reset SHALL occur on the (load_value+1)-th enabled cycle; subsequent pulses SHALL occur every load_value+1 enabled cycles.
REQ-013 load_value SHALL be sampled only at reset and at reload; changes mid-count SHALL NOT affect the current period.
REQ-014 load_value=0: out SHALL pulse on every enabled cycle; cnt stays 0.
REQ-015 load_value=2^WIDTH-1: period SHALL be 2^WIDTH enabled cycles; decrement SHALL never wrap below 0 (reload occurs instead).
REQ-016 count_en held continuously 1 SHALL produce back-to-back operation, with out high one cycle per load_value+1 clocks.
REQ-017 count_en is a level; a multi-cycle high level SHALL count once per clock, with no edge detection.
REQ-018 out SHALL be a plain pulse, not a toggle; downstream blink logic derives duty cycle externally.

Reset
REQ-019 When reset=0 at a rising clk, cnt SHALL load load_value and out SHALL be 0 on the next cycle, regardless of count_en.
REQ-020 Reset SHALL take priority over counting; reset asserted mid-period SHALL abort the period with no pulse.
REQ-021 Before the first reset edge, out and cnt SHALL be treated as undefined; there is no power-on initial value.
REQ-022 Counting SHALL resume on the first rising clk with reset=1, using the reloaded value.

Verification
REQ-023 WIDTH=9, load_value=8, 10 ns clk, count_en high 1 cycle in every 6, reset pulse low one cycle -> out pulses once per 9 enables (every 54 clk), each exactly 1 cycle wide.
REQ-024 load_value=8, count_en held 1 after reset -> out high on clk cycles 9, 18, 27, ... after reset release; low otherwise.
REQ-025 load_value=0, count_en held 1 -> out high every cycle; with count_en toggling 1/0 -> out high on the cycle after each enable.
REQ-026 load_value=8, count 4 enables, then reset low one cycle -> no pulse; next pulse after 9 further enables.
REQ-027 load_value changed 8->3 after 2 enables -> current period still ends after 9 enables; following periods are 4 enables.
REQ-028 count_en=0 for 100 cycles mid-period -> out stays 0, cnt holds; the pulse arrives after the remaining enables only.
